// File: rtl/mult16x9_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mult16x9_seq_ctrl
// Purpose : Iterative shift-and-add multiplier controller. It drives one
//           external carry-propagate adder and captures its sum each cycle.
//           It has valid/ready handshakes on the operand and product sides.
// Revision: 1.0  initial release
// ============================================================================
module mult16x9_seq_ctrl #(
  parameter int MD_WD   = 16,
  parameter int MR_WD   = 9,
  parameter int MDMR_WD = MD_WD + MR_WD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MD_WD-1:0]   in_md,
  input  logic [MR_WD-1:0]   in_mr,
  output logic [MDMR_WD-1:0] add_x,
  output logic [MDMR_WD-1:0] add_y,
  input  logic [MDMR_WD-1:0] add_sum,
  input  logic               add_cout,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MDMR_WD-1:0] out_prod,
  output logic               out_err
);

  localparam int CNT_WD = (MR_WD > 1) ? $clog2(MR_WD) : 1;
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(MR_WD - 1);
  localparam int PAD_WD = MDMR_WD - MD_WD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [MDMR_WD-1:0]  acc;
  logic [MD_WD-1:0]    md_q;
  logic [MR_WD-1:0]    mr_q;
  logic [CNT_WD-1:0]   cnt;
  logic                err;
  logic [MDMR_WD-1:0]  md_ext;

  assign md_ext = {{PAD_WD{1'b0}}, md_q};

  // Adder operands: accumulator plus the current shifted partial product,
  // forced to zero outside CALC so the shared adder sees quiet inputs.
  always_comb begin
    add_x = '0;
    add_y = '0;
    if (state == S_CALC) begin
      add_x = acc;
      if (mr_q[cnt]) begin
        add_y = md_ext << cnt;
      end
    end
  end

  assign out_prod = acc;
  assign out_err  = err;

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      md_q      <= '0;
      mr_q      <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            md_q     <= in_md;
            mr_q     <= in_mr;
            acc      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            state    <= S_CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_CALC: begin
          acc <= add_sum;
          err <= err | add_cout;
          if (cnt == CNT_LAST) begin
            // Park the counter at zero so it never indexes past mr_q.
            cnt       <= '0;
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          // No IDLE bypass: a new operand is taken one edge later at earliest.
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult16x9_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult16x9_seq_ctrl
// Purpose : Self-checking bench for mult16x9_seq_ctrl with an external adder
//           model, directed and random operands, and an arithmetic reference.
// Revision: 1.0  initial release
// ============================================================================
module tb_mult16x9_seq_ctrl;

  localparam int MD_WD   = 16;
  localparam int MR_WD   = 9;
  localparam int MDMR_WD = 25;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [MD_WD-1:0]   in_md;
  logic [MR_WD-1:0]   in_mr;
  logic [MDMR_WD-1:0] add_x;
  logic [MDMR_WD-1:0] add_y;
  logic [MDMR_WD-1:0] add_sum;
  logic               add_cout;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [MDMR_WD-1:0] out_prod;
  logic               out_err;

  logic               force_cout;
  logic [MDMR_WD:0]   full_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External adder model with a fault-injection hook on the carry-out.
  assign full_sum = {1'b0, add_x} + {1'b0, add_y};
  assign add_sum  = full_sum[MDMR_WD-1:0];
  assign add_cout = full_sum[MDMR_WD] | force_cout;

  mult16x9_seq_ctrl #(
    .MD_WD  (MD_WD),
    .MR_WD  (MR_WD),
    .MDMR_WD(MDMR_WD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_md    (in_md),
    .in_mr    (in_mr),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod (out_prod),
    .out_err  (out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".add_x"},     32'(add_x),     32'd0);
    check({tag, ".add_y"},     32'(add_y),     32'd0);
  endtask

  // One full operation: accept, MR_WD compute cycles, DONE with backpressure.
  task automatic run_op(input logic [15:0] md, input logic [8:0] mr,
                        input int hold, input int force_iter, input bit exp_err);
    logic [31:0] prod;
    logic [31:0] exp_x;
    logic [31:0] exp_y;
    logic [31:0] held;
    int          guard;
    prod  = 32'(md) * 32'(mr);
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("wait_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_md    = md;
    in_mr    = mr;
    tick();
    in_valid = 1'($urandom);
    in_md    = 16'($urandom);
    in_mr    = 9'($urandom);
    for (int k = 0; k < MR_WD; k++) begin
      exp_x = 32'(md) * (32'(mr) & ((32'd1 << k) - 32'd1));
      exp_y = mr[k] ? (32'(md) << k) : 32'd0;
      check("calc.add_x",     32'(add_x),     exp_x);
      check("calc.add_y",     32'(add_y),     exp_y);
      check("calc.in_ready",  32'(in_ready),  32'd0);
      check("calc.busy",      32'(busy),      32'd1);
      check("calc.out_valid", 32'(out_valid), 32'd0);
      force_cout = (k == force_iter);
      out_ready  = 1'($urandom);
      tick();
      force_cout = 1'b0;
      in_valid   = 1'($urandom);
    end
    out_ready = 1'b0;
    check("done.out_valid", 32'(out_valid), 32'd1);
    check("done.out_prod",  32'(out_prod),  prod);
    check("done.out_err",   32'(out_err),   32'(exp_err));
    check("done.busy",      32'(busy),      32'd1);
    check("done.add_x",     32'(add_x),     32'd0);
    held = 32'(out_prod);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      in_md    = 16'($urandom);
      in_mr    = 9'($urandom);
      tick();
      check("hold.out_valid", 32'(out_valid), 32'd1);
      check("hold.out_prod",  32'(out_prod),  held);
      check("hold.in_ready",  32'(in_ready),  32'd0);
    end
    // Release; in_valid may also be high here and must not be taken yet.
    out_ready = 1'b1;
    in_valid  = 1'($urandom);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_idle("release");
  endtask

  initial begin
    logic [15:0] rmd;
    logic [8:0]  rmr;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_md      = '0;
    in_mr      = '0;
    out_ready  = 1'b0;
    force_cout = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset.out_prod", 32'(out_prod), 32'd0);
    check("reset.out_err",  32'(out_err),  32'd0);

    run_op(16'h1234, 9'h0AB, 0, -1, 1'b0);
    run_op(16'hFFFF, 9'h1FF, 0, -1, 1'b0);
    run_op(16'h0000, 9'h1FF, 0, -1, 1'b0);
    run_op(16'hFFFF, 9'h000, 0, -1, 1'b0);
    run_op(16'hBEEF, 9'h155, 20, -1, 1'b0);
    run_op(16'h0001, 9'h001, 0, 0, 1'b1);
    run_op(16'h0001, 9'h001, 0, -1, 1'b0);

    // Reset while computing: accept, run iterations 0..3, reset at iteration 4.
    in_valid = 1'b1;
    in_md    = 16'hA5A5;
    in_mr    = 9'h1C3;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    check("midrst.out_prod", 32'(out_prod), 32'd0);
    run_op(16'h00FF, 9'h0FF, 1, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rmd = 16'($urandom);
      rmr = 9'($urandom);
      run_op(rmd, rmr, int'($urandom_range(0, 3)), -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult16x9_seq_ctrl.md
Name: mult16x9_seq_ctrl

Overview:
Sequencing controller that computes an unsigned MD_WD x MR_WD product by iterative shift-and-add over one shared MDMR_WD-bit carry-propagate adder instance, which sits outside this block.
- The block owns the operand registers, the accumulator and the iteration counter.
- It drives the adder operands and captures the adder sum each cycle.
- It presents a valid/ready handshake on input and on output.
- Use: low-area alternative to the combinational 16x9 array multiplier, on the same datapath width.

Parameters:
- MD_WD, 16, multiplicand width.
- MR_WD, 9, multiplier width; also the number of compute iterations.
- MDMR_WD, MD_WD+MR_WD, product and adder width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands; high only in IDLE.
- in_md  in  MD_WD  multiplicand, unsigned.
- in_mr  in  MR_WD  multiplier, unsigned.
- add_x  out  MDMR_WD  adder operand x (accumulator).
- add_y  out  MDMR_WD  adder operand y (shifted partial product).
- add_sum  in  MDMR_WD  adder sum, combinational return from the external adder.
- add_cout  in  1  adder carry out.
- busy  out  1  high in CALC or DONE.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_prod  out  MDMR_WD  product.
- out_err  out  1  adder carry-out seen during this operation.

Behaviour:
- Reset (sync, active-high): state=IDLE; acc, md_q, mr_q, cnt cleared to 0; err cleared.
  - Resulting outputs: in_ready=1, busy=0, out_valid=0, out_prod=0, out_err=0, add_x=0, add_y=0.
  - rst has priority over every other event, including mid-CALC and in DONE; a pending product is discarded.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: latch md_q=in_md and mr_q=in_mr; set acc=0, cnt=0, err=0; go to CALC.
- CALC, iteration cnt = 0..MR_WD-1:
  - add_x=acc.
  - add_y = mr_q[cnt] ? (zero-extended md_q << cnt) : 0.
  - Each edge: acc<=add_sum; err<=err|add_cout; cnt<=cnt+1.
  - When cnt==MR_WD-1 at the edge, go to DONE.
  - Exactly MR_WD CALC cycles always run; there is no early termination for zero operands.
  - Counter width is clog2(MR_WD); it never wraps inside one operation.
- DONE:
  - out_valid=1, out_prod=acc, out_err=err.
  - Outputs are held stable while out_ready=0; backpressure is unlimited.
  - On out_ready at an edge, go to IDLE. The next operand pair can be accepted on the following edge at the earliest; there is no IDLE bypass.
- add_x and add_y are 0 whenever state!=CALC.
- Arithmetic: unsigned only. The full product always fits in MDMR_WD bits, so add_cout=1 indicates an adder fault, reported via out_err. The product value is still delivered.
- Latency: handshake accepted at edge T; CALC occupies cycles T+1..T+MR_WD; out_valid is high from cycle T+MR_WD+1.
  - Throughput, with out_ready held high: one product per MR_WD+2 cycles.
- in_valid in CALC or DONE: ignored (in_ready=0); in_md and in_mr may change freely.
- out_ready in IDLE or CALC: ignored.
- in_valid and out_ready both high in DONE: only the DONE->IDLE transition happens; the input is accepted on a later cycle.

Test Plan:
- Reset then in_md=0x1234, in_mr=0x0AB, out_ready=1 -> out_valid rises exactly 10 cycles after the accept edge; out_prod=0x00C28BC; out_err=0; in_ready=0 throughout.
- in_md=0xFFFF, in_mr=0x1FF -> out_prod=0x1FEFE01; each CALC cycle add_y=0xFFFF<<cnt.
- in_md=0x0000, in_mr=0x1FF, then in_md=0xFFFF, in_mr=0x000 -> both give out_prod=0 after a full 9-cycle CALC.
- out_ready held 0 for 20 cycles in DONE while in_valid toggles with new operands -> out_prod and out_valid stable; no new accept; IDLE is entered one edge after out_ready=1.
- rst asserted at CALC iteration 4 -> next cycle: IDLE, acc=0, out_valid=0, in_ready=1; a fresh operation then completes correctly.
- Bench forces add_cout=1 for one CALC cycle with in_md=0x0001, in_mr=0x001 -> out_err=1 and out_prod=0x0000001; the next operation reports out_err=0.
